// File: rtl/covariance_engine.sv
// Streaming covariance-matrix engine: buffers M samples of N signed variables,
// centres them on their means and streams out the normalised N x N covariance.
module covariance_engine #(
   parameter int N          = 4,
   parameter int M          = 16,
   parameter int DATA_W     = 16,
   parameter int ACC_W      = 48,
   parameter int UPPER_ONLY = 0,
   parameter int BIASED     = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [DATA_W-1:0]  in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic signed [ACC_W-1:0]   out_data,
   output logic [$clog2(N)-1:0]      out_row,
   output logic [$clog2(N)-1:0]      out_col,
   output logic                      out_last,
   output logic                      busy,
   output logic [2:0]                dbg_state
);

   localparam int I_W   = $clog2(N);
   localparam int S_W   = $clog2(M);
   localparam int SUM_W = DATA_W + S_W + 1;
   localparam int C_W   = DATA_W + 1;
   localparam int P_W   = 2 * C_W;
   localparam logic [I_W-1:0]          V_LAST = I_W'(N - 1);
   localparam logic [S_W-1:0]          S_LAST = S_W'(M - 1);
   localparam logic signed [SUM_W-1:0] M_DIV  = SUM_W'(M);
   localparam logic signed [ACC_W-1:0] D_DIV  = ACC_W'((BIASED != 0) ? M : M - 1);

   typedef enum logic [2:0] {
      ST_LOAD   = 3'd0,
      ST_MEAN   = 3'd1,
      ST_CENTER = 3'd2,
      ST_MAC    = 3'd3,
      ST_DIV    = 3'd4,
      ST_OUT    = 3'd5
   } state_t;

   state_t                  state;
   logic signed [C_W-1:0]   data_buf [M][N];
   logic signed [SUM_W-1:0] sum      [N];
   logic signed [DATA_W-1:0] mean    [N];
   logic [S_W-1:0]          s_cnt;
   logic [I_W-1:0]          v_cnt;
   logic [I_W-1:0]          i_idx;
   logic [I_W-1:0]          j_idx;
   logic signed [ACC_W-1:0] acc;
   logic signed [C_W-1:0]   mac_a;
   logic signed [C_W-1:0]   mac_b;
   logic signed [P_W-1:0]   prod;
   logic                    last_pair;

   // Handshakes: a transfer happens on a rising edge where valid && ready;
   // a producer holds valid and its payload stable until that edge.
   assign in_ready  = (state == ST_LOAD);
   assign busy      = !((state == ST_LOAD) && (s_cnt == '0) && (v_cnt == '0));
   assign dbg_state = state;
   assign last_pair = (i_idx == V_LAST) && (j_idx == V_LAST);

   assign mac_a = data_buf[s_cnt][i_idx];
   assign mac_b = data_buf[s_cnt][j_idx];
   assign prod  = mac_a * mac_b;

   // Sample storage is never reset; it is fully rewritten by every data set.
   always_ff @(posedge clk) begin
      if (state == ST_LOAD && in_valid) begin
         data_buf[s_cnt][v_cnt] <= C_W'(in_data);
      end else if (state == ST_CENTER) begin
         data_buf[s_cnt][v_cnt] <= data_buf[s_cnt][v_cnt] - C_W'(mean[v_cnt]);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_LOAD;
         s_cnt     <= '0;
         v_cnt     <= '0;
         i_idx     <= '0;
         j_idx     <= '0;
         acc       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_row   <= '0;
         out_col   <= '0;
         out_last  <= 1'b0;
         for (int v = 0; v < N; v++) begin
            sum[v]  <= '0;
            mean[v] <= '0;
         end
      end else begin
         case (state)
            ST_LOAD: begin
               if (in_valid) begin
                  sum[v_cnt] <= sum[v_cnt] + SUM_W'(in_data);
                  if (v_cnt == V_LAST) begin
                     v_cnt <= '0;
                     if (s_cnt == S_LAST) begin
                        s_cnt <= '0;
                        state <= ST_MEAN;
                     end else begin
                        s_cnt <= s_cnt + 1'b1;
                     end
                  end else begin
                     v_cnt <= v_cnt + 1'b1;
                  end
               end
            end
            ST_MEAN: begin
               mean[v_cnt] <= DATA_W'(sum[v_cnt] / M_DIV);
               if (v_cnt == V_LAST) begin
                  v_cnt <= '0;
                  state <= ST_CENTER;
               end else begin
                  v_cnt <= v_cnt + 1'b1;
               end
            end
            ST_CENTER: begin
               if (v_cnt == V_LAST) begin
                  v_cnt <= '0;
                  if (s_cnt == S_LAST) begin
                     s_cnt <= '0;
                     acc   <= '0;
                     state <= ST_MAC;
                  end else begin
                     s_cnt <= s_cnt + 1'b1;
                  end
               end else begin
                  v_cnt <= v_cnt + 1'b1;
               end
            end
            ST_MAC: begin
               acc <= acc + ACC_W'(prod);
               if (s_cnt == S_LAST) begin
                  s_cnt <= '0;
                  state <= ST_DIV;
               end else begin
                  s_cnt <= s_cnt + 1'b1;
               end
            end
            ST_DIV: begin
               out_data  <= acc / D_DIV;
               out_row   <= i_idx;
               out_col   <= j_idx;
               out_last  <= last_pair;
               out_valid <= 1'b1;
               state     <= ST_OUT;
            end
            ST_OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  acc       <= '0;
                  if (last_pair) begin
                     i_idx <= '0;
                     j_idx <= '0;
                     for (int v = 0; v < N; v++) sum[v] <= '0;
                     state <= ST_LOAD;
                  end else begin
                     // Row-major walk; the upper-triangle walk restarts each row on the diagonal.
                     if (j_idx == V_LAST) begin
                        i_idx <= i_idx + 1'b1;
                        j_idx <= (UPPER_ONLY != 0) ? i_idx + 1'b1 : '0;
                     end else begin
                        j_idx <= j_idx + 1'b1;
                     end
                     state <= ST_MAC;
                  end
               end
            end
            default: state <= ST_LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_covariance_engine.sv
// Scoreboard bench for covariance_engine: three instances cover unbiased,
// biased and upper-triangle configurations with hand-computed matrices.
module tb_covariance_engine;

   localparam int PW = 65;
   typedef logic [PW-1:0] pk_t;

   logic clk = 1'b0;
   logic reset;
   logic signed [15:0] in_data;

   logic in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_last_a, busy_a;
   logic [0:0] out_row_a, out_col_a;
   logic signed [47:0] out_data_a;
   logic [2:0] dbg_state_a;

   logic in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_last_b, busy_b;
   logic [0:0] out_row_b, out_col_b;
   logic signed [47:0] out_data_b;
   logic [2:0] dbg_state_b;

   logic in_valid_c, in_ready_c, out_valid_c, out_ready_c, out_last_c, busy_c;
   logic [1:0] out_row_c, out_col_c;
   logic signed [47:0] out_data_c;
   logic [2:0] dbg_state_c;

   int tests_run = 0;
   int tests_failed = 0;
   int bp_mode = 0;
   int stim[$];
   pk_t exp_a[$];
   pk_t exp_b[$];
   pk_t exp_c[$];

   always #5 clk = ~clk;

   covariance_engine #(.N(2), .M(3), .DATA_W(16), .ACC_W(48), .UPPER_ONLY(0), .BIASED(0)) dut_a (
      .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data),
      .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a), .out_row(out_row_a),
      .out_col(out_col_a), .out_last(out_last_a), .busy(busy_a), .dbg_state(dbg_state_a));

   covariance_engine #(.N(2), .M(3), .DATA_W(16), .ACC_W(48), .UPPER_ONLY(0), .BIASED(1)) dut_b (
      .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data),
      .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b), .out_row(out_row_b),
      .out_col(out_col_b), .out_last(out_last_b), .busy(busy_b), .dbg_state(dbg_state_b));

   covariance_engine #(.N(3), .M(4), .DATA_W(16), .ACC_W(48), .UPPER_ONLY(1), .BIASED(0)) dut_c (
      .clk(clk), .reset(reset), .in_valid(in_valid_c), .in_ready(in_ready_c), .in_data(in_data),
      .out_valid(out_valid_c), .out_ready(out_ready_c), .out_data(out_data_c), .out_row(out_row_c),
      .out_col(out_col_c), .out_last(out_last_c), .busy(busy_c), .dbg_state(dbg_state_c));

   function automatic pk_t pk(input int row, input int col, input logic last, input logic [47:0] data);
      logic [7:0] r;
      logic [7:0] c;
      r = row[7:0];
      c = col[7:0];
      return {r, c, last, data};
   endfunction

   task automatic check(input string name, input pk_t act, input pk_t exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail(input string name, input string what);
      tests_run++;
      tests_failed++;
      $display("FAIL %s: %s", name, what);
   endtask

   task automatic push(input int inst, input int r, input int c, input logic l, input longint d);
      pk_t p;
      p = pk(r, c, l, d[47:0]);
      case (inst)
         0: exp_a.push_back(p);
         1: exp_b.push_back(p);
         default: exp_c.push_back(p);
      endcase
   endtask

   function automatic int qsize(input int inst);
      case (inst)
         0: return exp_a.size();
         1: return exp_b.size();
         default: return exp_c.size();
      endcase
   endfunction

   function automatic logic rdy(input int inst);
      case (inst)
         0: return in_ready_a;
         1: return in_ready_b;
         default: return in_ready_c;
      endcase
   endfunction

   task automatic set_valid(input int inst, input logic v);
      case (inst)
         0: in_valid_a = v;
         1: in_valid_b = v;
         default: in_valid_c = v;
      endcase
   endtask

   // Feeds the stim queue sample-major, holding each value until accepted.
   task automatic drive(input int inst);
      int t;
      for (int k = 0; k < stim.size(); k++) begin
         @(negedge clk);
         in_data = 16'(stim[k]);
         set_valid(inst, 1'b1);
         t = 0;
         while (!rdy(inst) && t < 2000) begin
            @(negedge clk);
            t++;
         end
         if (t >= 2000) begin
            fail("drive_timeout", $sformatf("inst %0d sample %0d never accepted", inst, k));
            set_valid(inst, 1'b0);
            return;
         end
         @(posedge clk);
      end
      @(negedge clk);
      set_valid(inst, 1'b0);
   endtask

   task automatic wait_empty(input int inst);
      int t = 0;
      while (qsize(inst) != 0 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (qsize(inst) != 0) begin
         fail("drain_timeout", $sformatf("inst %0d still expects %0d elements", inst, qsize(inst)));
         case (inst)
            0: exp_a.delete();
            1: exp_b.delete();
            default: exp_c.delete();
         endcase
      end
      repeat (10) @(negedge clk);
   endtask

   initial begin
      out_ready_a = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (bp_mode)
            0: out_ready_a = 1'b1;
            1: out_ready_a = 1'($urandom_range(0, 1));
            default: out_ready_a = 1'b0;
         endcase
      end
   end

   pk_t  cur_a, held_a, cur_b, cur_c;
   logic pend_a = 1'b0;

   always @(negedge clk) begin
      if (!reset) begin
         pend_a = 1'b0;
      end else if (out_valid_a) begin
         cur_a = pk(int'(out_row_a), int'(out_col_a), out_last_a, out_data_a);
         check("a_in_ready_low_in_out", pk_t'(in_ready_a), pk_t'(0));
         if (pend_a) check("a_stall_stable", cur_a, held_a);
         if (out_ready_a) begin
            if (exp_a.size() == 0) fail("a_unexpected", $sformatf("got %h expected nothing", cur_a));
            else check("a_elem", cur_a, exp_a.pop_front());
            pend_a = 1'b0;
         end else begin
            pend_a = 1'b1;
            held_a = cur_a;
         end
      end else if (pend_a) begin
         fail("a_valid_dropped", "got out_valid 0 expected 1 until handshake");
         pend_a = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (reset && out_valid_b && out_ready_b) begin
         cur_b = pk(int'(out_row_b), int'(out_col_b), out_last_b, out_data_b);
         if (exp_b.size() == 0) fail("b_unexpected", $sformatf("got %h expected nothing", cur_b));
         else check("b_elem", cur_b, exp_b.pop_front());
      end
   end

   always @(negedge clk) begin
      if (reset && out_valid_c && out_ready_c) begin
         cur_c = pk(int'(out_row_c), int'(out_col_c), out_last_c, out_data_c);
         if (exp_c.size() == 0) fail("c_unexpected", $sformatf("got %h expected nothing", cur_c));
         else check("c_elem", cur_c, exp_c.pop_front());
      end
   end

   initial begin
      int t;
      reset = 1'b0;
      in_data = '0;
      in_valid_a = 1'b0;
      in_valid_b = 1'b0;
      in_valid_c = 1'b0;
      out_ready_b = 1'b1;
      out_ready_c = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_in_ready", pk_t'(in_ready_a), pk_t'(1));
      check("rst_out_valid", pk_t'(out_valid_a), pk_t'(0));
      check("rst_busy", pk_t'(busy_a), pk_t'(0));
      check("rst_out_fields", pk(int'(out_row_a), int'(out_col_a), out_last_a, out_data_a), pk(0, 0, 0, 0));
      reset = 1'b1;

      // Positive correlation, unbiased
      push(0, 0, 0, 0, 1); push(0, 0, 1, 0, 2); push(0, 1, 0, 0, 2); push(0, 1, 1, 1, 4);
      stim = '{1, 2, 2, 4, 3, 6};
      drive(0);
      check("busy_after_load", pk_t'(busy_a), pk_t'(1));
      check("in_ready_after_load", pk_t'(in_ready_a), pk_t'(0));
      wait_empty(0);

      // Negative correlation
      push(0, 0, 0, 0, 1); push(0, 0, 1, 0, -2); push(0, 1, 0, 0, -2); push(0, 1, 1, 1, 4);
      stim = '{1, 6, 2, 4, 3, 2};
      drive(0);
      wait_empty(0);

      // Biased normalisation truncates 2/3, 4/3, 8/3
      push(1, 0, 0, 0, 0); push(1, 0, 1, 0, 1); push(1, 1, 0, 0, 1); push(1, 1, 1, 1, 2);
      stim = '{1, 2, 2, 4, 3, 6};
      drive(1);
      wait_empty(1);

      // Upper triangle, constant data
      push(2, 0, 0, 0, 0); push(2, 0, 1, 0, 0); push(2, 0, 2, 0, 0);
      push(2, 1, 1, 0, 0); push(2, 1, 2, 0, 0); push(2, 2, 2, 1, 0);
      stim = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5};
      drive(2);
      wait_empty(2);
      repeat (40) @(negedge clk);

      // Backpressure: 20-cycle hold low then random out_ready; negative truncation of -23/2
      push(0, 0, 0, 0, 21); push(0, 0, 1, 0, -11); push(0, 1, 0, 0, -11); push(0, 1, 1, 1, 10);
      bp_mode = 2;
      stim = '{3, -1, -2, 5, 7, 0};
      drive(0);
      t = 0;
      while (!out_valid_a && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!out_valid_a) fail("bp_first_valid", "got out_valid 0 expected 1 within 200 cycles");
      repeat (20) @(negedge clk);
      bp_mode = 1;
      wait_empty(0);
      bp_mode = 0;

      // Reset mid-MAC discards the set
      stim = '{1, 2, 2, 4, 3, 6};
      drive(0);
      t = 0;
      while (dbg_state_a != 3'd3 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (dbg_state_a != 3'd3) fail("reach_mac", $sformatf("got state %0d expected 3", dbg_state_a));
      #2;
      reset = 1'b0;
      #1;
      check("async_out_valid", pk_t'(out_valid_a), pk_t'(0));
      check("async_out_fields", pk(int'(out_row_a), int'(out_col_a), out_last_a, out_data_a), pk(0, 0, 0, 0));
      check("async_in_ready", pk_t'(in_ready_a), pk_t'(1));
      check("async_busy", pk_t'(busy_a), pk_t'(0));
      @(negedge clk);
      reset = 1'b1;

      // Back-to-back sets after reset; second set is offered while the first is still busy
      push(0, 0, 0, 0, 1); push(0, 0, 1, 0, 2); push(0, 1, 0, 0, 2); push(0, 1, 1, 1, 4);
      push(0, 0, 0, 0, 1); push(0, 0, 1, 0, -2); push(0, 1, 0, 0, -2); push(0, 1, 1, 1, 4);
      stim = '{1, 2, 2, 4, 3, 6};
      drive(0);
      stim = '{1, 6, 2, 4, 3, 2};
      drive(0);
      wait_empty(0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
